io_input_cond: RTL and testbench
================================

// Module: io_input_cond
// PURPOSE
//   Conditions the board switches and push-buttons before they reach the core's io_sw_i / io_btn_i inputs.
//   Provides per-bit synchronisation and debouncing, plus per-button press/release pulses.
//   Also keeps a sticky "pressed" flag per button that the core can clear.
//   Sits between the board pins and the singlecycle core's input-peripheral path.
// PARAMETERS
//   SW_WIDTH       32      number of slide switches
//   BTN_WIDTH      4       number of push-buttons
//   SYNC_STAGES    2       flip-flop synchroniser depth (>=2)
//   PRESCALE       50000   clock cycles per debounce tick (1 ms @ 50 MHz)
//   STABLE_TICKS   10      consecutive ticks a new level must hold before it is accepted (>=1)
//   BTN_ACTIVE_LOW 1       1: raw button pin low = pressed; 0: raw high = pressed
// PORTS
//   i_clk          in   1          system clock
//   i_rst          in   1          synchronous reset, active-high
//   i_sw_raw       in   SW_WIDTH   asynchronous switch pins
//   i_btn_raw      in   BTN_WIDTH  asynchronous button pins
//   i_btn_clr      in   BTN_WIDTH  write-one-to-clear strobe for o_btn_sticky (one cycle per bit)
//   o_sw_deb       out  SW_WIDTH   debounced switch levels -> core io_sw_i
//   o_btn_deb      out  BTN_WIDTH  debounced button levels, 1 = pressed -> core io_btn_i
//   o_btn_press    out  BTN_WIDTH  one-cycle pulse per debounced 0->1 transition
//   o_btn_release  out  BTN_WIDTH  one-cycle pulse per debounced 1->0 transition
//   o_btn_sticky   out  BTN_WIDTH  set on press, held until cleared
//   o_tick         out  1          debounce tick strobe (debug)
// BEHAVIOUR
//   Reset (i_rst=1 at a clock edge): all outputs 0.
//     - Synchroniser stages, debounced state, counters and prescaler are cleared to 0.
//     - Clearing happens on the clock edge only; reset is synchronous.
//   Polarity: when BTN_ACTIVE_LOW=1, buttons are inverted ahead of the synchroniser. Internal value 1 always means pressed. Switches are never inverted.
//   Synchroniser: SYNC_STAGES flops per bit. sync = the last stage.
//   Prescaler: counts 0..PRESCALE-1 and wraps.
//     - o_tick=1 in exactly the cycles where count==PRESCALE-1.
//     - Free-running; never gated by input activity.
//   Per-bit debounce FSM (same for switches and buttons). Each bit has a cnt of clog2(STABLE_TICKS+1) bits.
//     IDLE  (sync==deb):  cnt<=0.
//     COUNT (sync!=deb):
//       - tick && cnt==STABLE_TICKS-1: deb<=sync, cnt<=0.
//       - otherwise on tick: cnt<=cnt+1.
//       - no tick: hold.
//     Leaving COUNT because sync returns to deb sets cnt<=0 (glitch rejected, no output change).
//     cnt never exceeds STABLE_TICKS-1 and never wraps.
//   Accept latency from a clean step on a pin to the change on o_*_deb:
//     - minimum SYNC_STAGES+(STABLE_TICKS-1)*PRESCALE+1 cycles;
//     - maximum SYNC_STAGES+STABLE_TICKS*PRESCALE+1 cycles.
//   Edge pulses are registered and derived from the previous debounced value (deb_q):
//     - o_btn_press = deb & ~deb_q;
//     - o_btn_release = ~deb & deb_q;
//     - each asserts 1 cycle after o_btn_deb changes and lasts exactly 1 cycle.
//   Sticky flag, per bit, on the next edge:
//     - press pulse sets the bit;
//     - i_btn_clr clears it;
//     - press and clr in the same cycle: set wins, so no press is lost;
//     - clr of an already-clear bit does nothing.
//   Buttons held through reset release: reported as a normal press after the debounce latency.
//   Reset asserted mid-count: the count is discarded. The bit restarts debounce from 0 after reset.
//   All bits are independent. Simultaneous changes on several bits are handled in parallel with no arbitration.
// TESTING  (PRESCALE=4, STABLE_TICKS=3, SYNC_STAGES=2, BTN_ACTIVE_LOW=1)
//   1 Reset: i_rst=1 for 3 cycles with i_btn_raw=4'hF, i_sw_raw=32'hFFFF_FFFF.
//     -> all outputs 0 while reset is high.
//     -> after release, o_sw_deb becomes 32'hFFFF_FFFF within 2+12+1 cycles.
//   2 Clean press: i_btn_raw[0] 1->0 and held.
//     -> o_btn_deb[0] rises between cycle 11 and cycle 15 after the step.
//     -> o_btn_press[0] is high for exactly 1 cycle, on the next cycle.
//     -> o_btn_sticky[0]=1.
//   3 Glitch: i_btn_raw[1] low for 6 cycles, then high.
//     -> o_btn_deb[1], o_btn_press[1] and o_btn_sticky[1] stay 0.
//   4 Release and clear:
//     - i_btn_clr[0] pulse after test 2 -> o_btn_sticky[0]=0.
//     - then raw[0] back to 1 -> o_btn_release[0] 1-cycle pulse; o_btn_sticky[0] stays 0.
//   5 Set/clear collision: i_btn_clr[2]=1 in the same cycle as o_btn_press[2]=1.
//     -> o_btn_sticky[2]=1 on the next cycle.
//   6 Reset mid-count: i_sw_raw[5] toggles; i_rst pulses for 1 cycle after 6 cycles.
//     -> o_sw_deb[5]=0 after reset.
//     -> o_sw_deb[5] updates only after a full new debounce interval.

Source files
------------

// File: rtl/io_input_cond.sv
// -----------------------------------------------------------------------------
// io_input_cond
//   Conditions the board slide switches and push-buttons before they reach the
//   core's io_sw_i / io_btn_i inputs. Every bit gets a flop synchroniser and a
//   tick-based debouncer. Each button also produces registered press/release
//   pulses and a sticky "pressed" flag that the core clears by writing one.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_sw_raw       asynchronous switch pins
//   i_btn_raw      asynchronous button pins (polarity set by BTN_ACTIVE_LOW)
//   i_btn_clr      write-one-to-clear strobe for o_btn_sticky
//   o_sw_deb       debounced switch levels
//   o_btn_deb      debounced button levels, 1 = pressed
//   o_btn_press    one-cycle pulse per debounced 0->1 button transition
//   o_btn_release  one-cycle pulse per debounced 1->0 button transition
//   o_btn_sticky   set on press, held until cleared (set wins over clear)
//   o_tick         debounce tick strobe (debug)
// -----------------------------------------------------------------------------
module io_input_cond #(
  parameter int SW_WIDTH       = 32,
  parameter int BTN_WIDTH      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE       = 50000,
  parameter int STABLE_TICKS   = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_clr,
  output logic [SW_WIDTH-1:0]  o_sw_deb,
  output logic [BTN_WIDTH-1:0] o_btn_deb,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic [BTN_WIDTH-1:0] o_btn_release,
  output logic [BTN_WIDTH-1:0] o_btn_sticky,
  output logic                 o_tick
);

  // Switches and buttons share one debounce datapath: switches occupy the low
  // SW_WIDTH bits, buttons the top BTN_WIDTH bits.
  localparam int N  = SW_WIDTH + BTN_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  // Per-bit debounce state. It is not stored separately: a bit is counting
  // exactly when its synchronised value disagrees with its debounced value.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } db_state_e;

  logic [N-1:0]           raw_cond;
  logic [N-1:0]           sync_q [SYNC_STAGES];
  logic [N-1:0]           sync_d [SYNC_STAGES];
  logic [N-1:0]           sync;
  logic [PW-1:0]          pre_q, pre_d;
  logic                   tick;
  logic [N-1:0]           deb_q, deb_d;
  logic [CW-1:0]          cnt_q [N];
  logic [CW-1:0]          cnt_d [N];
  db_state_e              db_state [N];
  logic [BTN_WIDTH-1:0]   deb_btn;
  logic [BTN_WIDTH-1:0]   deb_prev_q, deb_prev_d;
  logic [BTN_WIDTH-1:0]   press_q, press_d;
  logic [BTN_WIDTH-1:0]   release_q, release_d;
  logic [BTN_WIDTH-1:0]   sticky_q, sticky_d;

  // Buttons are flipped before the synchroniser so that 1 means pressed
  // everywhere downstream.
  assign raw_cond = {i_btn_raw ^ {BTN_WIDTH{BTN_ACTIVE_LOW}}, i_sw_raw};

  // Synchroniser shift chain.
  always_comb begin
    sync_d[0] = raw_cond;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Free-running prescaler; the tick is the last count of each period.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // Debounce next-state. A new level is accepted on the STABLE_TICKS-th tick
  // seen while it continuously disagrees with the debounced value; any return
  // to agreement discards the partial count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]    = cnt_q[i];
      db_state[i] = (sync[i] != deb_q[i]) ? ST_COUNT : ST_IDLE;
      case (db_state[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
        end
        ST_COUNT: begin
          if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              deb_d[i] = sync[i];
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  assign deb_btn = deb_q[N-1 -: BTN_WIDTH];

  // Edge pulses compare the debounced value with its one-cycle-old copy and
  // are registered, so they appear the cycle after o_btn_deb changes.
  always_comb begin
    deb_prev_d = deb_btn;
    press_d    = deb_btn & ~deb_prev_q;
    release_d  = ~deb_btn & deb_prev_q;
    // Set has priority over clear so a press coinciding with a clear is kept.
    sticky_d   = (sticky_q & ~i_btn_clr) | press_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      pre_q      <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      sticky_q   <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pre_q      <= pre_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      release_q  <= release_d;
      sticky_q   <= sticky_d;
    end
  end

  assign o_sw_deb      = deb_q[SW_WIDTH-1:0];
  assign o_btn_deb     = deb_btn;
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;
  assign o_btn_sticky  = sticky_q;
  assign o_tick        = tick;

endmodule

// File: tb/tb_io_input_cond.sv
// -----------------------------------------------------------------------------
// tb_io_input_cond
//   Directed scenarios followed by randomized pin activity. A reference model
//   tracks, per bit, the cycle at which the synchronised pin began to disagree
//   with the debounced level and counts elapsed ticks arithmetically from the
//   prescaler phase. All outputs are compared after every clock edge.
// -----------------------------------------------------------------------------
module tb_io_input_cond;

  localparam int SW   = 32;
  localparam int BTN  = 4;
  localparam int N    = SW + BTN;
  localparam int SYNC = 2;
  localparam int P    = 4;
  localparam int ST   = 3;

  // Clock / reset and DUT signals
  logic           clk = 1'b0;
  logic           rst;
  logic [SW-1:0]  sw_raw;
  logic [BTN-1:0] btn_raw;
  logic [BTN-1:0] btn_clr;
  logic [SW-1:0]  sw_deb;
  logic [BTN-1:0] btn_deb;
  logic [BTN-1:0] btn_press;
  logic [BTN-1:0] btn_release;
  logic [BTN-1:0] btn_sticky;
  logic           tick;

  io_input_cond #(
    .SW_WIDTH      (SW),
    .BTN_WIDTH     (BTN),
    .SYNC_STAGES   (SYNC),
    .PRESCALE      (P),
    .STABLE_TICKS  (ST),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_raw     (sw_raw),
    .i_btn_raw    (btn_raw),
    .i_btn_clr    (btn_clr),
    .o_sw_deb     (sw_deb),
    .o_btn_deb    (btn_deb),
    .o_btn_press  (btn_press),
    .o_btn_release(btn_release),
    .o_btn_sticky (btn_sticky),
    .o_tick       (tick)
  );

  always #5 clk = ~clk;

  // Scoreboard counters
  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (values the DUT outputs should hold after an edge)
  logic [N-1:0]   m_hist[$];     // conditioned pin history, [0] = oldest
  logic [N-1:0]   m_deb;
  int             m_start [N];   // cycle index where disagreement began, -1 none
  logic [BTN-1:0] m_db_prev;
  logic [BTN-1:0] m_press;
  logic [BTN-1:0] m_rel;
  logic [BTN-1:0] m_sticky;
  int             m_k;           // cycles since reset released

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int s = 0; s < SYNC; s++) m_hist.push_back('0);
    m_deb     = '0;
    m_db_prev = '0;
    m_press   = '0;
    m_rel     = '0;
    m_sticky  = '0;
    m_k       = 0;
    for (int i = 0; i < N; i++) m_start[i] = -1;
  endtask

  // Advance the model across one clock edge using the inputs present at it.
  task automatic model_edge();
    logic [N-1:0]   s;
    logic [N-1:0]   deb_new;
    logic [BTN-1:0] db;
    logic [BTN-1:0] press_new;
    logic [BTN-1:0] rel_new;
    logic [BTN-1:0] sticky_new;
    bit             tick_now;
    int             ticks_seen;
    if (rst) begin
      model_reset();
      return;
    end
    s        = m_hist[0];
    tick_now = ((m_k % P) == P - 1);
    deb_new  = m_deb;
    for (int i = 0; i < N; i++) begin
      if (s[i] == m_deb[i]) begin
        m_start[i] = -1;
      end else begin
        if (m_start[i] < 0) m_start[i] = m_k;
        // number of tick cycles within [m_start, m_k]
        ticks_seen = (m_k + 1) / P - m_start[i] / P;
        if (tick_now && ticks_seen == ST) begin
          deb_new[i] = s[i];
          m_start[i] = -1;
        end
      end
    end
    db         = m_deb[N-1:SW];
    press_new  = db & ~m_db_prev;
    rel_new    = ~db & m_db_prev;
    sticky_new = (m_sticky & ~btn_clr) | m_press;
    m_db_prev  = db;
    m_deb      = deb_new;
    m_press    = press_new;
    m_rel      = rel_new;
    m_sticky   = sticky_new;
    void'(m_hist.pop_front());
    m_hist.push_back({~btn_raw, sw_raw});
    m_k++;
  endtask

  task automatic check_all();
    chk("sw_deb",      64'(sw_deb),      64'(m_deb[SW-1:0]));
    chk("btn_deb",     64'(btn_deb),     64'(m_deb[N-1:SW]));
    chk("btn_press",   64'(btn_press),   64'(m_press));
    chk("btn_release", 64'(btn_release), 64'(m_rel));
    chk("btn_sticky",  64'(btn_sticky),  64'(m_sticky));
    chk("tick",        64'(tick),        64'((m_k % P) == P - 1));
  endtask

  // Driver: one clock cycle, then compare outputs 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int             n;
    bit             found;
    bit             early;
    int             idx;
    logic [N-1:0]   pins;

    model_reset();
    rst     = 1'b1;
    sw_raw  = '1;
    btn_raw = '1;
    btn_clr = '0;

    // 1: reset with all pins high, then switches accepted within latency
    run(3);
    chk("reset_sw_zero",  64'(sw_deb),     64'(0));
    chk("reset_sticky",   64'(btn_sticky), 64'(0));
    rst   = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= 2 + 12 + 1 && !found; i++) begin
      cyc();
      if (sw_deb == '1) found = 1'b1;
    end
    chk("reset_sw_accept", 64'(found), 64'(1));
    chk("reset_btn_idle",  64'(btn_deb), 64'(0));
    run(5);

    // 2: clean press on button 0
    btn_raw[0] = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      cyc();
      n++;
      if (btn_deb[0]) found = 1'b1;
    end
    chk("press_latency_window", 64'(found && n >= 11 && n <= 15), 64'(1));
    chk("press_not_yet",  64'(btn_press[0]), 64'(0));
    cyc();
    chk("press_pulse",    64'(btn_press[0]), 64'(1));
    cyc();
    chk("press_pulse_end", 64'(btn_press[0]), 64'(0));
    chk("press_sticky",   64'(btn_sticky[0]), 64'(1));

    // 3: six-cycle glitch on button 1 must be rejected
    btn_raw[1] = 1'b0;
    run(6);
    btn_raw[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (btn_deb[1] || btn_press[1] || btn_sticky[1]) found = 1'b1;
    end
    chk("glitch_rejected", 64'(found), 64'(0));

    // 4: clear sticky 0, then release button 0
    btn_clr[0] = 1'b1;
    cyc();
    btn_clr[0] = 1'b0;
    chk("clr_sticky0", 64'(btn_sticky[0]), 64'(0));
    btn_raw[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (btn_release[0]) found = 1'b1;
    end
    chk("release_seen",     64'(found), 64'(1));
    chk("release_sticky0",  64'(btn_sticky[0]), 64'(0));
    cyc();
    chk("release_pulse_end", 64'(btn_release[0]), 64'(0));

    // 5: clear collides with press on button 2, set wins
    btn_raw[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (btn_press[2]) found = 1'b1;
    end
    chk("collide_press_seen", 64'(found), 64'(1));
    btn_clr[2] = 1'b1;
    cyc();
    btn_clr[2] = 1'b0;
    chk("collide_sticky_set", 64'(btn_sticky[2]), 64'(1));
    btn_raw[2] = 1'b1;
    run(20);

    // 6: reset in the middle of a switch-5 count
    sw_raw[5] = 1'b0;
    run(20);
    chk("sw5_low_settled", 64'(sw_deb[5]), 64'(0));
    sw_raw[5] = 1'b1;
    run(6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midcount_reset_sw5", 64'(sw_deb[5]), 64'(0));
    found = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 15 && !found; i++) begin
      cyc();
      if (sw_deb[5]) begin
        found = 1'b1;
        if (i < 11) early = 1'b1;
      end
    end
    chk("midcount_full_interval", 64'(found && !early), 64'(1));

    // Random phase: noisy bursts, quiet stretches, random clears, rare resets
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 15; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          idx        = $urandom_range(0, N - 1);
          pins       = {btn_raw, sw_raw};
          pins[idx]  = ~pins[idx];
          {btn_raw, sw_raw} = pins;
        end
        btn_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
        cyc();
      end
      n = $urandom_range(10, 40);
      for (int c = 0; c < n; c++) begin
        btn_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
        rst     = ($urandom_range(0, 399) == 0);
        cyc();
      end
      rst     = 1'b0;
      btn_clr = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
